ex_result_buf: RTL and testbench
================================

// Module: ex_result_buf
// PURPOSE
//  Execute-stage output buffer sitting directly downstream of the ALU. Captures
//  ALU result + flags with per-instruction sideband (rd, writeback enable,
//  branch info), resolves the branch condition from the flags, and presents
//  a registered beat to the memory stage. 2-entry skid buffer: full
//  throughput, registered in_ready, no combinational ready path.
// PARAMETERS
//  Width     32  datapath width of result and branch target
//  RegAddrW  5   destination register index width
// PORTS
//  clk           in   1         clock, all state on rising edge
//  rst_n         in   1         asynchronous reset, active-low
//  flush         in   1         synchronous squash of all buffered beats
//  in_valid      in   1         upstream beat valid
//  in_ready      out  1         buffer can accept (registered)
//  in_res        in   Width     ALU result
//  in_flags      in   alu_flags_t  rvcpu::alu_flags_t {zero,overflow,negative,carry}
//  in_rd         in   RegAddrW  destination register
//  in_wb_en      in   1         instruction writes rd
//  in_is_branch  in   1         instruction is a conditional branch
//  in_br_cond    in   3         branch funct3
//  in_br_target  in   Width     precomputed branch target
//  out_valid     out  1         downstream beat valid
//  out_ready     in   1         downstream accepts
//  out_res       out  Width     buffered result
//  out_flags     out  alu_flags_t  buffered flags
//  out_rd        out  RegAddrW  buffered rd
//  out_wb_en     out  1         buffered wb enable
//  out_br_taken  out  1         resolved branch outcome (0 if not a branch)
//  out_br_target out  Width     buffered target
//  occupancy     out  2         entries held: 0, 1 or 2
// BEHAVIOUR
//  - Reset (rst_n=0, async): both entries invalid; out_valid=0, in_ready=1,
//    occupancy=0, all data outputs 0. Deasserting mid-transfer drops beats.
//  - Accept when in_valid&&in_ready; emit when out_valid&&out_ready.
//  - Entries: MAIN drives outputs; SKID holds an overflow beat.
//    States EMPTY(0) / ONE(1) / FULL(2):
//    EMPTY: accept -> ONE (beat in MAIN, out_valid next cycle; latency 1).
//    ONE: accept&emit -> ONE (new beat in MAIN); accept only -> FULL (SKID);
//         emit only -> EMPTY.
//    FULL: in_ready=0; emit -> ONE (SKID moves to MAIN same edge).
//  - in_ready = !skid_valid, registered; a FULL buffer accepts nothing that
//    cycle even if out_ready=1.
//  - Branch resolution at capture, stored with the beat:
//    lt = in_res[Width-1] ^ in_flags.overflow; ltu = !in_flags.carry
//    000 beq=zero, 001 bne=!zero, 100 blt=lt, 101 bge=!lt,
//    110 bltu=ltu, 111 bgeu=!ltu, 010/011 -> 0; AND with in_is_branch.
//  - flush=1: next edge both entries invalid, occupancy=0, in_ready=1; beat
//    offered that cycle is dropped; out_valid remains combinationally tied to
//    MAIN valid, so a downstream handshake in the flush cycle still completes.
//  - Data regs load only on accept/shift; no change while out_valid&&!out_ready.
//  - Ordering strictly FIFO; no beat duplicated or lost except on flush/reset.
// TESTING
//  - Reset then 1 beat res=0x0000_002A rd=5 wb_en=1, out_ready=1 -> out_valid
//    next cycle, out_res=0x2A, out_rd=5, occupancy 1 then 0.
//  - Stream 8 beats with out_ready=1 -> 1 beat/cycle, in_ready stays 1, order kept.
//  - out_ready=0, push 3 beats -> first two held (occupancy=2), in_ready=0,
//    third stalled; release out_ready -> beats out in order, third accepted.
//  - Branch: res=0xFFFF_FFFF overflow=0 cond=100 -> taken=1; zero=1 cond=001
//    -> 0; carry=0 cond=110 -> 1; cond=010 -> 0; is_branch=0 -> 0.
//  - FULL + flush with in_valid=1 -> next cycle out_valid=0, occupancy=0,
//    in_ready=1, offered beat never appears.
//  - rst_n low mid-stall at occupancy=2 -> outputs reset immediately, clk-free.

Source files
------------

// File: rtl/ex_result_buf.sv
// Execute-stage result buffer: 2-entry skid buffer between ALU and memory stage.
// Resolves branch outcome at capture so the stored beat carries br_taken.
package rvcpu;
  typedef struct packed {
    logic zero;
    logic overflow;
    logic negative;
    logic carry;
  } alu_flags_t;
endpackage

module ex_result_buf
  import rvcpu::*;
#(
  parameter int Width    = 32,
  parameter int RegAddrW = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [Width-1:0]    in_res,
  input  alu_flags_t          in_flags,
  input  logic [RegAddrW-1:0] in_rd,
  input  logic                in_wb_en,
  input  logic                in_is_branch,
  input  logic [2:0]          in_br_cond,
  input  logic [Width-1:0]    in_br_target,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [Width-1:0]    out_res,
  output alu_flags_t          out_flags,
  output logic [RegAddrW-1:0] out_rd,
  output logic                out_wb_en,
  output logic                out_br_taken,
  output logic [Width-1:0]    out_br_target,
  output logic [1:0]          occupancy
);

  typedef struct packed {
    logic [Width-1:0]    res;
    alu_flags_t          flags;
    logic [RegAddrW-1:0] rd;
    logic                wb_en;
    logic                br_taken;
    logic [Width-1:0]    br_target;
  } beat_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t state, state_nxt;
  beat_t  main_q, skid_q, in_beat;
  logic   accept, emit;
  logic   ld_main_in, ld_main_skid, ld_skid;
  logic   lt, ltu, cond_hit;

  always_comb begin
    lt  = in_res[Width-1] ^ in_flags.overflow;
    ltu = !in_flags.carry;
    case (in_br_cond)
      3'b000:  cond_hit = in_flags.zero;
      3'b001:  cond_hit = !in_flags.zero;
      3'b100:  cond_hit = lt;
      3'b101:  cond_hit = !lt;
      3'b110:  cond_hit = ltu;
      3'b111:  cond_hit = !ltu;
      default: cond_hit = 1'b0;
    endcase
  end

  always_comb begin
    in_beat.res       = in_res;
    in_beat.flags     = in_flags;
    in_beat.rd        = in_rd;
    in_beat.wb_en     = in_wb_en;
    in_beat.br_taken  = cond_hit & in_is_branch;
    in_beat.br_target = in_br_target;
  end

  // Ready and valid decode straight from the state register: no input-to-ready path.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          ld_main_in = 1'b1;
          state_nxt  = ONE;
        end
        ONE: begin
          if (accept && emit) begin
            ld_main_in = 1'b1;
          end else if (accept) begin
            ld_skid   = 1'b1;
            state_nxt = FULL;
          end else if (emit) begin
            state_nxt = EMPTY;
          end
        end
        FULL: if (emit) begin
          ld_main_skid = 1'b1;
          state_nxt    = ONE;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_in)        main_q <= in_beat;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= in_beat;
    end
  end

  assign out_res       = main_q.res;
  assign out_flags     = main_q.flags;
  assign out_rd        = main_q.rd;
  assign out_wb_en     = main_q.wb_en;
  assign out_br_taken  = main_q.br_taken;
  assign out_br_target = main_q.br_target;

endmodule

// File: tb/tb_ex_result_buf.sv
// Bench for ex_result_buf: queue-based FIFO model, branch vector table,
// directed corner sequences and a randomized handshake/flush run.
module tb_ex_result_buf;
  import rvcpu::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush, in_valid, in_ready;
  logic [31:0]      in_res, in_br_target;
  alu_flags_t       in_flags;
  logic [4:0]       in_rd;
  logic             in_wb_en, in_is_branch;
  logic [2:0]       in_br_cond;
  logic             out_valid, out_ready;
  logic [31:0]      out_res, out_br_target;
  alu_flags_t       out_flags;
  logic [4:0]       out_rd;
  logic             out_wb_en, out_br_taken;
  logic [1:0]       occupancy;

  ex_result_buf #(.Width(32), .RegAddrW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_res(in_res), .in_flags(in_flags), .in_rd(in_rd), .in_wb_en(in_wb_en),
    .in_is_branch(in_is_branch), .in_br_cond(in_br_cond), .in_br_target(in_br_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_flags(out_flags), .out_rd(out_rd), .out_wb_en(out_wb_en),
    .out_br_taken(out_br_taken), .out_br_target(out_br_target),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flags;
    logic [4:0]  rd;
    logic        wb;
    logic        isb;
    logic [2:0]  cond;
    logic [31:0] target;
  } tb_beat_t;

  typedef struct {
    tb_beat_t b;
    logic     exp_taken;
  } br_vec_t;

  tb_beat_t q[$];
  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Branch outcome straight from the ISA rules (signed/unsigned less-than).
  function automatic logic br_ref(input tb_beat_t b);
    logic lt, ltu, t;
    lt  = b.res[31] ^ b.flags[2];
    ltu = !b.flags[0];
    case (b.cond)
      3'd0: t = b.flags[3];
      3'd1: t = !b.flags[3];
      3'd4: t = lt;
      3'd5: t = !lt;
      3'd6: t = ltu;
      3'd7: t = !ltu;
      default: t = 1'b0;
    endcase
    return t & b.isb;
  endfunction

  function automatic tb_beat_t rand_beat();
    tb_beat_t b;
    b.res    = $urandom;
    b.flags  = 4'($urandom_range(0, 15));
    b.rd     = 5'($urandom_range(0, 31));
    b.wb     = 1'($urandom_range(0, 1));
    b.isb    = 1'($urandom_range(0, 1));
    b.cond   = 3'($urandom_range(0, 7));
    b.target = $urandom;
    return b;
  endfunction

  task automatic compare_all();
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    if (q.size() > 0) begin
      chk("out_res", 64'(out_res), 64'(q[0].res));
      chk("out_flags", 64'(out_flags), 64'(q[0].flags));
      chk("out_rd", 64'(out_rd), 64'(q[0].rd));
      chk("out_wb_en", 64'(out_wb_en), 64'(q[0].wb));
      chk("out_br_taken", 64'(out_br_taken), 64'(br_ref(q[0])));
      chk("out_br_target", 64'(out_br_target), 64'(q[0].target));
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic v, input tb_beat_t b, input logic r, input logic f);
    bit acc, emt;
    compare_all();
    in_valid = v; out_ready = r; flush = f;
    in_res = b.res; in_flags = b.flags; in_rd = b.rd; in_wb_en = b.wb;
    in_is_branch = b.isb; in_br_cond = b.cond; in_br_target = b.target;
    acc = v && (q.size() < 2);
    emt = (q.size() > 0) && r;
    @(posedge clk);
    if (f) q.delete();
    else begin
      if (emt) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    @(negedge clk);
  endtask

  br_vec_t  tbl[11];
  tb_beat_t nb, b0, b1, b2;

  initial begin
    nb = '0;
    tbl[0]  = '{'{32'hFFFF_FFFF, 4'b0000, 5'd1, 1'b0, 1'b1, 3'b100, 32'h100}, 1'b1};
    tbl[1]  = '{'{32'h0000_0000, 4'b1000, 5'd2, 1'b0, 1'b1, 3'b001, 32'h104}, 1'b0};
    tbl[2]  = '{'{32'h0000_0010, 4'b0000, 5'd3, 1'b0, 1'b1, 3'b110, 32'h108}, 1'b1};
    tbl[3]  = '{'{32'h0000_0000, 4'b1000, 5'd4, 1'b0, 1'b1, 3'b010, 32'h10C}, 1'b0};
    tbl[4]  = '{'{32'h0000_0000, 4'b1000, 5'd5, 1'b1, 1'b0, 3'b000, 32'h110}, 1'b0};
    tbl[5]  = '{'{32'h0000_0000, 4'b1000, 5'd6, 1'b0, 1'b1, 3'b000, 32'h114}, 1'b1};
    tbl[6]  = '{'{32'h7FFF_FFFF, 4'b0100, 5'd7, 1'b0, 1'b1, 3'b101, 32'h118}, 1'b0};
    tbl[7]  = '{'{32'h0000_0001, 4'b0001, 5'd8, 1'b0, 1'b1, 3'b111, 32'h11C}, 1'b1};
    tbl[8]  = '{'{32'hFFFF_FFFF, 4'b0100, 5'd9, 1'b0, 1'b1, 3'b100, 32'h120}, 1'b0};
    tbl[9]  = '{'{32'h0000_0005, 4'b0000, 5'd10, 1'b0, 1'b1, 3'b001, 32'h124}, 1'b1};
    tbl[10] = '{'{32'h0000_0000, 4'b1000, 5'd11, 1'b0, 1'b1, 3'b011, 32'h128}, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_res = '0; in_flags = '0; in_rd = '0; in_wb_en = 1'b0;
    in_is_branch = 1'b0; in_br_cond = '0; in_br_target = '0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_out_res", 64'(out_res), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single beat, latency 1
    b0 = nb; b0.res = 32'h2A; b0.rd = 5'd5; b0.wb = 1'b1;
    step(1'b1, b0, 1'b1, 1'b0);
    chk("one_out_valid", 64'(out_valid), 64'd1);
    chk("one_out_res", 64'(out_res), 64'h2A);
    chk("one_out_rd", 64'(out_rd), 64'd5);
    chk("one_occ1", 64'(occupancy), 64'd1);
    step(1'b0, nb, 1'b1, 1'b0);
    chk("one_occ0", 64'(occupancy), 64'd0);

    // 8-beat stream at full rate
    for (int i = 0; i < 8; i++) begin
      b0 = rand_beat(); b0.res = 32'(i + 100);
      step(1'b1, b0, 1'b1, 1'b0);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      chk("stream_res", 64'(out_res), 64'(i + 100));
    end
    step(1'b0, nb, 1'b1, 1'b0);

    // branch vector table
    foreach (tbl[i]) begin
      step(1'b1, tbl[i].b, 1'b1, 1'b0);
      chk($sformatf("br_tbl%0d", i), 64'(out_br_taken), 64'(tbl[i].exp_taken));
    end
    step(1'b0, nb, 1'b1, 1'b0);

    // stall: two held, third stalled until space opens
    b0 = rand_beat(); b1 = rand_beat(); b2 = rand_beat();
    step(1'b1, b0, 1'b0, 1'b0);
    step(1'b1, b1, 1'b0, 1'b0);
    chk("stall_occ2", 64'(occupancy), 64'd2);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    step(1'b1, b2, 1'b0, 1'b0);
    chk("stall_hold_res", 64'(out_res), 64'(b0.res));
    step(1'b1, b2, 1'b1, 1'b0);
    chk("stall_rel_res", 64'(out_res), 64'(b1.res));
    step(1'b1, b2, 1'b1, 1'b0);
    chk("stall_third_res", 64'(out_res), 64'(b2.res));
    step(1'b0, nb, 1'b1, 1'b0);

    // flush from FULL with a beat offered
    step(1'b1, rand_beat(), 1'b0, 1'b0);
    step(1'b1, rand_beat(), 1'b0, 1'b0);
    step(1'b1, rand_beat(), 1'b0, 1'b1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) step(1'b0, nb, 1'b1, 1'b0);

    // async reset while FULL and stalled
    step(1'b1, rand_beat(), 1'b0, 1'b0);
    step(1'b1, rand_beat(), 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("pre_rst_occ", 64'(occupancy), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_res", 64'(out_res), 64'd0);
    chk("arst_out_rd", 64'(out_rd), 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // randomized handshakes with occasional flush
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_beat(), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 31) == 0));
    end
    compare_all();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
